// File: rtl/flac_fixed_pkg.sv
// Shared definitions for the FLAC fixed-predictor encoder/decoder family:
// FSM state encoding, datapath widths and the fixed-predictor coefficients.
// Related build option: FIXED_DECODER_MULTI_ORDER_EN (selectable order 0..4).
package flac_fixed_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int ACC_W     = 20;
    localparam int MAX_ORDER = 4;
    localparam int ORDER_W   = 3;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_DECODE = 2'd2
    } state_e;

    // Fixed-predictor taps: Cn_k multiplies the k-th most recent sample for order n.
    localparam acc_t C1_1 =  20'sd1;
    localparam acc_t C2_1 =  20'sd2;
    localparam acc_t C2_2 = -20'sd1;
    localparam acc_t C3_1 =  20'sd3;
    localparam acc_t C3_2 = -20'sd3;
    localparam acc_t C3_3 =  20'sd1;
    localparam acc_t C4_1 =  20'sd4;
    localparam acc_t C4_2 = -20'sd6;
    localparam acc_t C4_3 =  20'sd4;
    localparam acc_t C4_4 = -20'sd1;

    // Sign-extend a sample into the accumulator width.
    function automatic acc_t sext_acc(input sample_t s);
        return {{(ACC_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

endpackage

// File: rtl/fixed_predictor.sv
// Combinational fixed-order predictor: history s1..s4 and order in,
// ACC_W-wide prediction out. Orders above MAX_ORDER use the order-4 taps.
module fixed_predictor
    import flac_fixed_pkg::*;
(
    input  sample_t            s1_i,
    input  sample_t            s2_i,
    input  sample_t            s3_i,
    input  sample_t            s4_i,
    input  logic [ORDER_W-1:0] order_i,
    output acc_t               pred_o
);

    acc_t x1, x2, x3, x4;

    assign x1 = sext_acc(s1_i);
    assign x2 = sext_acc(s2_i);
    assign x3 = sext_acc(s3_i);
    assign x4 = sext_acc(s4_i);

    // Select the polynomial prediction for the requested order.
    always_comb begin
        pred_o = '0;
        case (order_i)
            3'd0:    pred_o = '0;
            3'd1:    pred_o = C1_1 * x1;
            3'd2:    pred_o = C2_1 * x1 + C2_2 * x2;
            3'd3:    pred_o = C3_1 * x1 + C3_2 * x2 + C3_3 * x3;
            default: pred_o = C4_1 * x1 + C4_2 * x2 + C4_3 * x3 + C4_4 * x4;
        endcase
    end

endmodule

// File: rtl/fixed_decoder_order4.sv
// FLAC fixed-predictor decoder. Falling-edge clocked, two-stage pipeline:
// inputs are registered on edge N, the reconstructed sample on edge N+1.
// The recurrence (history -> prediction -> sample -> history) closes in stage 2.
// Build option FIXED_DECODER_MULTI_ORDER_EN adds iOrder (0..4, latched on iStart);
// without it the order is fixed at 4.
// Handshake: iValid qualifies iResidual in the same cycle, no backpressure;
// oValid qualifies oSample for exactly one cycle per accepted input.
module fixed_decoder_order4
    import flac_fixed_pkg::*;
(
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iStart,
    input  logic               iValid,
    input  sample_t            iResidual,
`ifdef FIXED_DECODER_MULTI_ORDER_EN
    input  logic [ORDER_W-1:0] iOrder,
`endif
    output sample_t            oSample,
    output logic               oValid,
    output logic               oBusy,
    output state_e             oState
);

    localparam logic [ORDER_W-1:0] ORD_FIXED = ORDER_W'(MAX_ORDER);

    // Stage 1: registered inputs
    logic    start_q, vld_q;
    sample_t res_q;

    // Stage 2: FSM, history, warmup counter, output registers
    state_e             state_q, state_d;
    sample_t            s1_q, s2_q, s3_q, s4_q;
    sample_t            s1_d, s2_d, s3_d, s4_d;
    logic [ORDER_W-1:0] cnt_q, cnt_d;
    sample_t            sample_q, sample_d;
    logic               out_vld_q, out_vld_d;

    // Values as seen by this cycle, after applying a pending start
    state_e             eff_state;
    sample_t            e1, e2, e3, e4;
    logic [ORDER_W-1:0] eff_cnt, eff_order;
    logic [ORDER_W-1:0] ord_start, ord_cur;
    acc_t               pred;

`ifdef FIXED_DECODER_MULTI_ORDER_EN
    logic [ORDER_W-1:0] ord_in_q, order_q;

    // Clamp and register the requested order alongside the other inputs.
    always_ff @(negedge iClock or posedge iReset) begin
        if (iReset) ord_in_q <= ORD_FIXED;
        else        ord_in_q <= (iOrder > ORD_FIXED) ? ORD_FIXED : iOrder;
    end

    // Latch the block order when a start reaches stage 2.
    always_ff @(negedge iClock or posedge iReset) begin
        if (iReset)       order_q <= ORD_FIXED;
        else if (start_q) order_q <= ord_in_q;
    end

    assign ord_start = ord_in_q;
    assign ord_cur   = order_q;
`else
    assign ord_start = ORD_FIXED;
    assign ord_cur   = ORD_FIXED;
`endif

    // Stage 1 input registers.
    always_ff @(negedge iClock or posedge iReset) begin
        if (iReset) begin
            start_q <= 1'b0;
            vld_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            start_q <= iStart;
            vld_q   <= iValid;
            res_q   <= iResidual;
        end
    end

    // A start discards the running block: clear history/counter before use.
    always_comb begin
        eff_state = state_q;
        eff_cnt   = cnt_q;
        eff_order = ord_cur;
        e1 = s1_q;
        e2 = s2_q;
        e3 = s3_q;
        e4 = s4_q;
        if (start_q) begin
            eff_state = (ord_start == '0) ? ST_DECODE : ST_WARMUP;
            eff_cnt   = '0;
            eff_order = ord_start;
            e1 = '0;
            e2 = '0;
            e3 = '0;
            e4 = '0;
        end
    end

    fixed_predictor u_pred (
        .s1_i   (e1),
        .s2_i   (e2),
        .s3_i   (e3),
        .s4_i   (e4),
        .order_i(eff_order),
        .pred_o (pred)
    );

    // Next-state, history update and output sample for stage 2.
    always_comb begin
        state_d   = eff_state;
        cnt_d     = eff_cnt;
        sample_d  = sample_q;
        out_vld_d = 1'b0;
        s1_d = e1;
        s2_d = e2;
        s3_d = e3;
        s4_d = e4;
        if (vld_q && (eff_state != ST_IDLE)) begin
            if (eff_state == ST_WARMUP) begin
                sample_d = res_q;
                cnt_d    = eff_cnt + 1'b1;
                if (cnt_d == eff_order) state_d = ST_DECODE;
            end else begin
                // Wraps mod 2^16, the exact inverse of the wrapping encoder.
                sample_d = SAMPLE_W'(sext_acc(res_q) + pred);
            end
            out_vld_d = 1'b1;
            s4_d = e3;
            s3_d = e2;
            s2_d = e1;
            s1_d = sample_d;
        end
    end

    // Stage 2 state register.
    always_ff @(negedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            s4_q      <= '0;
            sample_q  <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            s4_q      <= s4_d;
            sample_q  <= sample_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign oSample = sample_q;
    assign oValid  = out_vld_q;
    assign oBusy   = (state_q == ST_WARMUP) || (state_q == ST_DECODE);
    assign oState  = state_q;

endmodule

// File: tb/tb_fixed_decoder_order4.sv
// Directed bench for fixed_decoder_order4. Inputs change on the rising edge,
// the design acts on the falling edge. Each cyc() call carries the expected
// output for its own input; that expectation is checked two calls later.
module tb_fixed_decoder_order4;
    import flac_fixed_pkg::*;

    logic    clk = 1'b0;
    logic    rst, start, valid;
    sample_t res;
    sample_t o_sample;
    logic    o_valid, o_busy;
    state_e  o_state;
`ifdef FIXED_DECODER_MULTI_ORDER_EN
    logic [2:0] order;
`endif

    always #5 clk = ~clk;

    fixed_decoder_order4 dut (
        .iClock   (clk),
        .iReset   (rst),
        .iStart   (start),
        .iValid   (valid),
        .iResidual(res),
`ifdef FIXED_DECODER_MULTI_ORDER_EN
        .iOrder   (order),
`endif
        .oSample  (o_sample),
        .oValid   (o_valid),
        .oBusy    (o_busy),
        .oState   (o_state)
    );

    int errors = 0;
    int checks = 0;

    // Two-deep pipeline of expectations (p1 = previous call, p2 = two calls ago)
    logic  p1_v, p2_v;
    int    p1_s, p2_s;
    string p1_t, p2_t;

    int h[4];
    int x, r;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_pending();
        chk({p2_t, "/valid"}, o_valid, p2_v);
        if (p2_v) chk({p2_t, "/sample"}, o_sample, p2_s);
    endtask

    task automatic cyc(input logic s, input logic v, input int rv,
                       input logic ev, input int es, input string tag);
        @(posedge clk);
        check_pending();
        p2_v = p1_v; p2_s = p1_s; p2_t = p1_t;
        p1_v = ev;   p1_s = es;   p1_t = tag;
        start = s;
        valid = v;
        res   = rv[15:0];
    endtask

    task automatic flush();
        cyc(1'b0, 1'b0, 0, 1'b0, 0, "idle");
        cyc(1'b0, 1'b0, 0, 1'b0, 0, "idle");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; res = '0;
`ifdef FIXED_DECODER_MULTI_ORDER_EN
        order = 3'd4;
`endif
        p1_v = 1'b0; p2_v = 1'b0; p1_s = 0; p2_s = 0; p1_t = "none"; p2_t = "none";

        // Reset state
        repeat (2) @(posedge clk);
        chk("rst_sample", o_sample, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_state", o_state, ST_IDLE);
        @(negedge clk);
        #2 rst = 1'b0;

        // Valid inputs in IDLE are ignored
        cyc(1'b0, 1'b1, 7, 1'b0, 0, "idle_in7");
        cyc(1'b0, 1'b1, 8, 1'b0, 0, "idle_in8");
        flush();
        chk("idle_busy", o_busy, 0);

        // Ramp: 1,2,3,4 warmup then residuals 0,0 continue the ramp
        cyc(1'b1, 1'b0, 0, 1'b0, 0, "ramp_start");
        cyc(1'b0, 1'b1, 1, 1'b1, 1, "ramp_1");
        cyc(1'b0, 1'b1, 2, 1'b1, 2, "ramp_2");
        chk("ramp_busy", o_busy, 1);
        chk("ramp_warm_state", o_state, ST_WARMUP);
        cyc(1'b0, 1'b1, 3, 1'b1, 3, "ramp_3");
        cyc(1'b0, 1'b1, 4, 1'b1, 4, "ramp_4");
        cyc(1'b0, 1'b1, 0, 1'b1, 5, "ramp_5");
        cyc(1'b0, 1'b1, 0, 1'b1, 6, "ramp_6");
        flush();
        chk("ramp_dec_state", o_state, ST_DECODE);

        // Wrap, with iStart coincident with the first warmup sample
        cyc(1'b1, 1'b1, 0, 1'b1, 0, "wrap_w0");
        cyc(1'b0, 1'b1, 0, 1'b1, 0, "wrap_w1");
        cyc(1'b0, 1'b1, 0, 1'b1, 0, "wrap_w2");
        cyc(1'b0, 1'b1, 0, 1'b1, 0, "wrap_w3");
        cyc(1'b0, 1'b1, 32767, 1'b1, 32767, "wrap_r0");
        cyc(1'b0, 1'b1, 32767, 1'b1, 32763, "wrap_r1");
        flush();

        // Gap: iValid low for 3 cycles after input 3
        cyc(1'b1, 1'b0, 0, 1'b0, 0, "gap_start");
        cyc(1'b0, 1'b1, 1, 1'b1, 1, "gap_1");
        cyc(1'b0, 1'b1, 2, 1'b1, 2, "gap_2");
        cyc(1'b0, 1'b1, 3, 1'b1, 3, "gap_3");
        cyc(1'b0, 1'b0, 0, 1'b0, 0, "gap_hole_a");
        cyc(1'b0, 1'b0, 0, 1'b0, 0, "gap_hole_b");
        cyc(1'b0, 1'b0, 0, 1'b0, 0, "gap_hole_c");
        cyc(1'b0, 1'b1, 4, 1'b1, 4, "gap_4");
        cyc(1'b0, 1'b1, 0, 1'b1, 5, "gap_5");
        cyc(1'b0, 1'b1, 0, 1'b1, 6, "gap_6");
        flush();

        // Restart in DECODE: 9 is warmup, the next decode uses only 9..12
        cyc(1'b1, 1'b0, 0, 1'b0, 0, "rs_start");
        cyc(1'b0, 1'b1, 1, 1'b1, 1, "rs_1");
        cyc(1'b0, 1'b1, 2, 1'b1, 2, "rs_2");
        cyc(1'b0, 1'b1, 3, 1'b1, 3, "rs_3");
        cyc(1'b0, 1'b1, 4, 1'b1, 4, "rs_4");
        cyc(1'b0, 1'b1, 0, 1'b1, 5, "rs_5");
        cyc(1'b1, 1'b1, 9, 1'b1, 9, "rs_new9");
        cyc(1'b0, 1'b1, 10, 1'b1, 10, "rs_new10");
        cyc(1'b0, 1'b1, 11, 1'b1, 11, "rs_new11");
        cyc(1'b0, 1'b1, 12, 1'b1, 12, "rs_new12");
        cyc(1'b0, 1'b1, 0, 1'b1, 13, "rs_dec13");
        flush();

        // Reset between inputs 4 and 0: input 3 still shows, input 4 is dropped
        cyc(1'b1, 1'b0, 0, 1'b0, 0, "rt_start");
        cyc(1'b0, 1'b1, 1, 1'b1, 1, "rt_1");
        cyc(1'b0, 1'b1, 2, 1'b1, 2, "rt_2");
        cyc(1'b0, 1'b1, 3, 1'b1, 3, "rt_3");
        cyc(1'b0, 1'b1, 4, 1'b0, 0, "rt_4");
        @(posedge clk);
        check_pending();
        rst = 1'b1; start = 1'b0; valid = 1'b0; res = '0;
        #1;
        chk("mid_rst_sample", o_sample, 0);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_state", o_state, ST_IDLE);
        p1_v = 1'b0; p2_v = 1'b0; p1_t = "post_rst"; p2_t = "post_rst";
        @(negedge clk);
        #2 rst = 1'b0;
        cyc(1'b0, 1'b1, 0, 1'b0, 0, "rt_after_0a");
        cyc(1'b0, 1'b1, 0, 1'b0, 0, "rt_after_0b");
        flush();
        chk("rt_after_busy", o_busy, 0);
        cyc(1'b1, 1'b1, 1, 1'b1, 1, "rt_again_1");
        cyc(1'b0, 1'b1, 2, 1'b1, 2, "rt_again_2");
        cyc(1'b0, 1'b1, 3, 1'b1, 3, "rt_again_3");
        cyc(1'b0, 1'b1, 4, 1'b1, 4, "rt_again_4");
        cyc(1'b0, 1'b1, 0, 1'b1, 5, "rt_again_5");
        flush();

        // Round trip: random samples encoded with the wrapping order-4 encoder
        cyc(1'b1, 1'b0, 0, 1'b0, 0, "rtrip_start");
        for (int i = 0; i < 4; i++) h[i] = 0;
        for (int i = 0; i < 24; i++) begin
            x = int'($urandom_range(0, 65535)) - 32768;
            if (i < 4) r = x;
            else       r = x - (4 * h[0] - 6 * h[1] + 4 * h[2] - h[3]);
            cyc(1'b0, 1'b1, r, 1'b1, x, "rtrip");
            h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = x;
        end
        flush();

`ifdef FIXED_DECODER_MULTI_ORDER_EN
        // Order 1: warmup 32767, residual 1 wraps to -32768
        order = 3'd1;
        cyc(1'b1, 1'b1, 32767, 1'b1, 32767, "o1_warm");
        order = 3'd4;
        cyc(1'b0, 1'b1, 1, 1'b1, -32768, "o1_res");
        flush();
`endif

        flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
